// File: rtl/mux_controller.sv
// -----------------------------------------------------------------------------
// mux_controller
//
// Sequencing and data-steering controller for the CORDIC complex square root
// sqrt(x+jy) = sqrt(R) * (cos(theta/2) + j sin(theta/2)).
// It runs the shared CORDIC vectoring unit (CV) twice:
//   - pass 1 produces the angle directions and 2R-1;
//   - pass 2 produces sqrt(R) using operands R+0.25 and R-0.25.
// It then runs the CORDIC rotation unit (CR) with the captured micro-rotation
// directions and latches the final complex result.
//
// All data are Q2.14 two's complement (1.0 = 16'h4000).
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   x_in, y_in                   operand, captured when start is accepted
//   start                        request pulse, honoured only when idle
//   cv_calc_end, cv_di_valid     CV pass finished / direction bits valid
//   cv_di_microt, cv_2Rminus1    CV direction bits / CV result
//   cr_calc_end                  CR pass finished
//   cr_cos_theta, cr_sin_theta   CR result (real / imag)
//   cr_di_microt                 latched direction bits to CR
//   start_cv, start_cr           one-cycle start pulses to CV / CR
//   xin_cv, yin_cv               CV operands
//   yn_cv                        held pass-1 result (2R-1)
//   xin_cr, yin_cr               CR operands
//   cmplx_sqrt_real/_imag        result, held until the next result
//   cmplx_sqrt_valid             one-cycle result strobe
//
// Every output is a register.
// -----------------------------------------------------------------------------
module mux_controller (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    input  logic               start,
    input  logic               cv_calc_end,
    input  logic               cr_calc_end,
    input  logic               cv_di_valid,
    input  logic        [31:0] cv_di_microt,
    input  logic signed [15:0] cv_2Rminus1,
    input  logic signed [15:0] cr_cos_theta,
    input  logic signed [15:0] cr_sin_theta,
    output logic        [31:0] cr_di_microt,
    output logic               start_cv,
    output logic               start_cr,
    output logic signed [15:0] xin_cv,
    output logic signed [15:0] yin_cv,
    output logic signed [15:0] yn_cv,
    output logic signed [15:0] xin_cr,
    output logic signed [15:0] yin_cr,
    output logic signed [15:0] cmplx_sqrt_real,
    output logic signed [15:0] cmplx_sqrt_imag,
    output logic               cmplx_sqrt_valid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CV1_GO   = 3'd1,
        CV1_WAIT = 3'd2,
        CV2_GO   = 3'd3,
        CV2_WAIT = 3'd4,
        CR_GO    = 3'd5,
        CR_WAIT  = 3'd6,
        DONE     = 3'd7
    } state_t;

    // (2R-1)/2 + 0.75 = R + 0.25 and (2R-1)/2 + 0.25 = R - 0.25
    localparam logic signed [15:0] C_OFS_X = 16'sh3000;
    localparam logic signed [15:0] C_OFS_Y = 16'sh1000;

    // Halve with arithmetic shift and add an offset; the sum wraps in 16 bits.
    function automatic logic signed [15:0] half_plus(
        input logic signed [15:0] a,
        input logic signed [15:0] ofs
    );
        return (a >>> 1) + ofs;
    endfunction

    state_t      r_state;
    logic [31:0] r_di;
    logic        r_di_seen;   // a cv_di_valid beat has arrived during pass 1

    logic signed [15:0] w_cv2_x;
    logic signed [15:0] w_cv2_y;

    assign w_cv2_x = half_plus(cv_2Rminus1, C_OFS_X);
    assign w_cv2_y = half_plus(cv_2Rminus1, C_OFS_Y);

    // Outputs are loaded on the edge that enters each *_GO state so that the
    // start pulse and its operands appear together in the GO cycle.
    // xin_cv/yin_cv hold the captured operand during pass 1, yn_cv holds the
    // pass-1 result and xin_cr holds the pass-2 result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_di             <= '0;
            r_di_seen        <= 1'b0;
            cr_di_microt     <= '0;
            start_cv         <= 1'b0;
            start_cr         <= 1'b0;
            xin_cv           <= '0;
            yin_cv           <= '0;
            yn_cv            <= '0;
            xin_cr           <= '0;
            yin_cr           <= '0;
            cmplx_sqrt_real  <= '0;
            cmplx_sqrt_imag  <= '0;
            cmplx_sqrt_valid <= 1'b0;
        end else begin
            start_cv         <= 1'b0;
            start_cr         <= 1'b0;
            cmplx_sqrt_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        xin_cv    <= x_in;
                        yin_cv    <= y_in;
                        r_di_seen <= 1'b0;
                        start_cv  <= 1'b1;
                        r_state   <= CV1_GO;
                    end
                end

                CV1_GO: r_state <= CV1_WAIT;

                CV1_WAIT: begin
                    if (cv_di_valid) begin
                        r_di      <= cv_di_microt;
                        r_di_seen <= 1'b1;
                    end
                    if (cv_calc_end) begin
                        // No direction beat seen: take the bits present at the end.
                        if (!r_di_seen && !cv_di_valid) begin
                            r_di <= cv_di_microt;
                        end
                        yn_cv    <= cv_2Rminus1;
                        xin_cv   <= w_cv2_x;
                        yin_cv   <= w_cv2_y;
                        start_cv <= 1'b1;
                        r_state  <= CV2_GO;
                    end
                end

                CV2_GO: r_state <= CV2_WAIT;

                CV2_WAIT: begin
                    if (cv_calc_end) begin
                        xin_cr       <= cv_2Rminus1;
                        yin_cr       <= '0;
                        cr_di_microt <= r_di;
                        start_cr     <= 1'b1;
                        r_state      <= CR_GO;
                    end
                end

                CR_GO: r_state <= CR_WAIT;

                CR_WAIT: begin
                    if (cr_calc_end) begin
                        cmplx_sqrt_real  <= cr_cos_theta;
                        cmplx_sqrt_imag  <= cr_sin_theta;
                        cmplx_sqrt_valid <= 1'b1;
                        r_state          <= DONE;
                    end
                end

                DONE: r_state <= IDLE;

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_controller.sv
// -----------------------------------------------------------------------------
// tb_mux_controller
//
// Directed bench for mux_controller. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
// The CV and CR engines are modelled by hand-placed calc_end / di pulses.
// -----------------------------------------------------------------------------
module tb_mux_controller;

    logic        clk;
    logic        rst;
    logic [15:0] x_in, y_in;
    logic        start;
    logic        cv_calc_end, cr_calc_end, cv_di_valid;
    logic [31:0] cv_di_microt;
    logic [15:0] cv_2Rminus1, cr_cos_theta, cr_sin_theta;
    logic [31:0] cr_di_microt;
    logic        start_cv, start_cr;
    logic [15:0] xin_cv, yin_cv, yn_cv, xin_cr, yin_cr;
    logic [15:0] cmplx_sqrt_real, cmplx_sqrt_imag;
    logic        cmplx_sqrt_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mux_controller dut (
        .clk              (clk),
        .rst              (rst),
        .x_in             (x_in),
        .y_in             (y_in),
        .start            (start),
        .cv_calc_end      (cv_calc_end),
        .cr_calc_end      (cr_calc_end),
        .cv_di_valid      (cv_di_valid),
        .cv_di_microt     (cv_di_microt),
        .cv_2Rminus1      (cv_2Rminus1),
        .cr_cos_theta     (cr_cos_theta),
        .cr_sin_theta     (cr_sin_theta),
        .cr_di_microt     (cr_di_microt),
        .start_cv         (start_cv),
        .start_cr         (start_cr),
        .xin_cv           (xin_cv),
        .yin_cv           (yin_cv),
        .yn_cv            (yn_cv),
        .xin_cr           (xin_cr),
        .yin_cr           (yin_cr),
        .cmplx_sqrt_real  (cmplx_sqrt_real),
        .cmplx_sqrt_imag  (cmplx_sqrt_imag),
        .cmplx_sqrt_valid (cmplx_sqrt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        x_in = '0; y_in = '0; start = 1'b0;
        cv_calc_end = 1'b0; cr_calc_end = 1'b0; cv_di_valid = 1'b0;
        cv_di_microt = '0; cv_2Rminus1 = '0; cr_cos_theta = '0; cr_sin_theta = '0;
        rst = 1'b0;

        // Asynchronous reset, asserted before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_start_cv", {31'd0, start_cv}, 32'd0);
        check("rst_xin_cv",   {16'd0, xin_cv}, 32'd0);
        check("rst_real",     {16'd0, cmplx_sqrt_real}, 32'd0);
        check("rst_valid",    {31'd0, cmplx_sqrt_valid}, 32'd0);
        check("rst_cr_di",    cr_di_microt, 32'd0);
        tick; tick;
        rst = 1'b0;

        // Stray cr_calc_end while idle
        tick;
        cr_calc_end = 1'b1; cr_cos_theta = 16'h1111; cr_sin_theta = 16'h2222;
        tick;
        cr_calc_end = 1'b0;
        check("idle_stray_real",  {16'd0, cmplx_sqrt_real}, 32'd0);
        check("idle_stray_valid", {31'd0, cmplx_sqrt_valid}, 32'd0);
        check("idle_stray_scv",   {31'd0, start_cv}, 32'd0);

        // ---- Operation 1: nominal flow ----
        x_in = 16'h4000; y_in = 16'h0000; start = 1'b1;
        tick;
        start = 1'b0;
        check("op1_start_cv", {31'd0, start_cv}, 32'd1);
        check("op1_xin_cv",   {16'd0, xin_cv}, 32'h4000);
        check("op1_yin_cv",   {16'd0, yin_cv}, 32'h0000);
        tick;
        check("op1_scv_pulse", {31'd0, start_cv}, 32'd0);
        // busy start with a different operand
        start = 1'b1; x_in = 16'h1234; y_in = 16'h5678;
        tick;
        start = 1'b0;
        check("busy_start_cv", {31'd0, start_cv}, 32'd0);
        check("busy_xin_cv",   {16'd0, xin_cv}, 32'h4000);
        check("busy_yin_cv",   {16'd0, yin_cv}, 32'h0000);
        cv_di_valid = 1'b1; cv_di_microt = 32'hA5A5_0F0F;
        tick;
        cv_di_valid = 1'b0; cv_di_microt = 32'hDEAD_BEEF;
        repeat (10) tick;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h4000;
        tick;
        cv_calc_end = 1'b0;
        check("op1_cv2_start", {31'd0, start_cv}, 32'd1);
        check("op1_cv2_x",     {16'd0, xin_cv}, 32'h5000);
        check("op1_cv2_y",     {16'd0, yin_cv}, 32'h3000);
        check("op1_yn_cv",     {16'd0, yn_cv}, 32'h4000);
        tick;
        check("op1_cv2_pulse", {31'd0, start_cv}, 32'd0);
        // direction beat during pass 2 must be ignored
        cv_di_valid = 1'b1; cv_di_microt = 32'h1234_5678;
        tick;
        cv_di_valid = 1'b0;
        repeat (3) tick;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h4000; cv_di_microt = 32'h0;
        tick;
        cv_calc_end = 1'b0;
        check("op1_start_cr", {31'd0, start_cr}, 32'd1);
        check("op1_xin_cr",   {16'd0, xin_cr}, 32'h4000);
        check("op1_yin_cr",   {16'd0, yin_cr}, 32'h0000);
        check("op1_cr_di",    cr_di_microt, 32'hA5A5_0F0F);
        tick;
        check("op1_cr_pulse", {31'd0, start_cr}, 32'd0);
        // stray cv_calc_end in CR_WAIT
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h7777;
        tick;
        cv_calc_end = 1'b0;
        check("crw_stray_scv",   {31'd0, start_cv}, 32'd0);
        check("crw_stray_yn",    {16'd0, yn_cv}, 32'h4000);
        check("crw_stray_xcv",   {16'd0, xin_cv}, 32'h5000);
        check("crw_stray_xcr",   {16'd0, xin_cr}, 32'h4000);
        check("crw_stray_valid", {31'd0, cmplx_sqrt_valid}, 32'd0);
        cr_calc_end = 1'b1; cr_cos_theta = 16'h4000; cr_sin_theta = 16'h0000;
        tick;
        cr_calc_end = 1'b0; cr_cos_theta = 16'h7F7F; cr_sin_theta = 16'h7F7F;
        check("op1_valid", {31'd0, cmplx_sqrt_valid}, 32'd1);
        check("op1_real",  {16'd0, cmplx_sqrt_real}, 32'h4000);
        check("op1_imag",  {16'd0, cmplx_sqrt_imag}, 32'h0000);
        tick;
        check("op1_valid_pulse", {31'd0, cmplx_sqrt_valid}, 32'd0);
        check("op1_real_hold",   {16'd0, cmplx_sqrt_real}, 32'h4000);

        // ---- Operation 2: back-to-back, di and calc_end together, negative m ----
        x_in = 16'hE000; y_in = 16'h2000; start = 1'b1;
        tick;
        start = 1'b0;
        check("op2_start_cv", {31'd0, start_cv}, 32'd1);
        check("op2_xin_cv",   {16'd0, xin_cv}, 32'hE000);
        check("op2_yin_cv",   {16'd0, yin_cv}, 32'h2000);
        check("op2_real_held", {16'd0, cmplx_sqrt_real}, 32'h4000);
        tick; tick;
        cv_di_valid = 1'b1; cv_di_microt = 32'h0000_FFFF;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'hC000;
        tick;
        cv_di_valid = 1'b0; cv_calc_end = 1'b0; cv_di_microt = 32'h0;
        check("op2_cv2_start", {31'd0, start_cv}, 32'd1);
        check("op2_cv2_x",     {16'd0, xin_cv}, 32'h1000);
        check("op2_cv2_y",     {16'd0, yin_cv}, 32'hF000);
        check("op2_yn_cv",     {16'd0, yn_cv}, 32'hC000);
        tick; tick;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h2D41;
        tick;
        cv_calc_end = 1'b0;
        check("op2_start_cr", {31'd0, start_cr}, 32'd1);
        check("op2_xin_cr",   {16'd0, xin_cr}, 32'h2D41);
        check("op2_cr_di",    cr_di_microt, 32'h0000_FFFF);
        check("op2_real_hold", {16'd0, cmplx_sqrt_real}, 32'h4000);
        tick; tick;
        cr_calc_end = 1'b1; cr_cos_theta = 16'h1234; cr_sin_theta = 16'hEDCC;
        tick;
        cr_calc_end = 1'b0;
        check("op2_valid", {31'd0, cmplx_sqrt_valid}, 32'd1);
        check("op2_real",  {16'd0, cmplx_sqrt_real}, 32'h1234);
        check("op2_imag",  {16'd0, cmplx_sqrt_imag}, 32'hEDCC);
        tick; tick;

        // ---- Operation 3: no di beat in pass 1, then reset mid-operation ----
        x_in = 16'h1000; y_in = 16'h1000; start = 1'b1;
        tick;
        start = 1'b0;
        check("op3_start_cv", {31'd0, start_cv}, 32'd1);
        tick; tick;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h0000; cv_di_microt = 32'hCAFE_F00D;
        tick;
        cv_calc_end = 1'b0; cv_di_microt = 32'h0;
        check("op3_cv2_x", {16'd0, xin_cv}, 32'h3000);
        check("op3_cv2_y", {16'd0, yin_cv}, 32'h1000);
        tick;
        cv_calc_end = 1'b1; cv_2Rminus1 = 16'h3000;
        tick;
        cv_calc_end = 1'b0;
        check("op3_start_cr", {31'd0, start_cr}, 32'd1);
        check("op3_cr_di",    cr_di_microt, 32'hCAFE_F00D);
        check("op3_xin_cr",   {16'd0, xin_cr}, 32'h3000);
        tick;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_xin_cr", {16'd0, xin_cr}, 32'd0);
        check("mid_rst_cr_di",  cr_di_microt, 32'd0);
        check("mid_rst_xin_cv", {16'd0, xin_cv}, 32'd0);
        check("mid_rst_yn_cv",  {16'd0, yn_cv}, 32'd0);
        check("mid_rst_real",   {16'd0, cmplx_sqrt_real}, 32'd0);
        check("mid_rst_imag",   {16'd0, cmplx_sqrt_imag}, 32'd0);
        cr_calc_end = 1'b1; cr_cos_theta = 16'h5555; cr_sin_theta = 16'h5555;
        tick;
        rst = 1'b0;
        tick;
        cr_calc_end = 1'b0;
        check("post_rst_valid", {31'd0, cmplx_sqrt_valid}, 32'd0);
        check("post_rst_real",  {16'd0, cmplx_sqrt_real}, 32'd0);

        // ---- Operation 4: accepted right after reset, so FSM is idle ----
        x_in = 16'h0ABC; y_in = 16'h0000; start = 1'b1;
        tick;
        start = 1'b0;
        check("op4_start_cv", {31'd0, start_cv}, 32'd1);
        check("op4_xin_cv",   {16'd0, xin_cv}, 32'h0ABC);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
